// File: rtl/stream_frame_arbiter.sv
// stream_frame_arbiter
// Frame-aligned round-robin arbiter that merges NUM_SRC AXI4-Stream sources of
// packed complex sample vectors into one registered output stream. A grant is
// held for a whole frame so frames from different sources never interleave, and
// the granted source index travels with each beat on m_axis_tuser.
//
// Optional feature macro: STREAM_FRAME_ARB_LEN_CHECK_EN
//   defined   : frame length comes from a beat counter, m_axis_tlast is generated
//               from that count, and frame_err pulses when a source's tlast
//               disagrees with the count.
//   undefined : frame ends on the granted source's tlast, which is passed through;
//               no beat counter, frame_err is held at 0.

module stream_frame_arbiter #(
    parameter int NUM_SRC      = 2,
    parameter int WIDTH        = 16,
    parameter int SAMP_PER_CLK = 4,
    parameter int FFT_LEN      = 16,
    localparam int DW          = SAMP_PER_CLK * 2 * WIDTH,
    localparam int IW          = ($clog2(NUM_SRC) > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC*DW-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]    s_axis_tvalid,
    input  logic [NUM_SRC-1:0]    s_axis_tlast,
    output logic [NUM_SRC-1:0]    s_axis_tready,
    output logic [DW-1:0]         m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [IW-1:0]         m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  frame_err
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state;
    logic [IW-1:0] grant;
    logic [IW-1:0] ptr;
    logic          out_ready;
    logic          accept;
    logic          eof;
    logic          sel_found;
    logic [IW-1:0] sel_idx;

`ifdef STREAM_FRAME_ARB_LEN_CHECK_EN
    localparam int BEATS = FFT_LEN / SAMP_PER_CLK;
    localparam int CW    = ($clog2(BEATS) > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0] beat_cnt;
    logic          cnt_last;

    assign cnt_last = (beat_cnt == CW'(BEATS - 1));
    assign eof      = cnt_last;
`else
    assign eof      = s_axis_tlast[grant];
`endif

    // Catch illegal configurations when the design is elaborated.
    if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_bad_num_src
        $error("stream_frame_arbiter: NUM_SRC must be in 2..8");
    end
    if (FFT_LEN < SAMP_PER_CLK || (FFT_LEN % SAMP_PER_CLK) != 0) begin : g_bad_fft_len
        $error("stream_frame_arbiter: FFT_LEN must be a multiple of SAMP_PER_CLK");
    end

    // Index k steps away from base, wrapped into 0..NUM_SRC-1.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_SRC) begin
            s = s - NUM_SRC;
        end
        return IW'(s);
    endfunction

    // The output register can take a new beat when it is empty or being drained.
    assign out_ready = !m_axis_tvalid || m_axis_tready;
    assign accept    = (state == BUSY) && s_axis_tvalid[grant] && out_ready;

    // Round-robin scan: first valid source at or after ptr.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!sel_found && s_axis_tvalid[wrap_add(ptr, k)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_add(ptr, k);
            end
        end
    end

    // Only the granted source sees ready, and only while a frame is in progress.
    always_comb begin
        s_axis_tready = '0;
        if (!rst && state == BUSY && out_ready) begin
            s_axis_tready[grant] = 1'b1;
        end
    end

    // Arbitration FSM together with the registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= '0;
            ptr           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            frame_err     <= 1'b0;
`ifdef STREAM_FRAME_ARB_LEN_CHECK_EN
            beat_cnt      <= '0;
`endif
        end else begin
            frame_err <= 1'b0;

            if (accept) begin
                m_axis_tdata  <= s_axis_tdata[grant*DW +: DW];
                m_axis_tuser  <= grant;
                m_axis_tlast  <= eof;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant <= sel_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept) begin
`ifdef STREAM_FRAME_ARB_LEN_CHECK_EN
                        beat_cnt  <= cnt_last ? '0 : beat_cnt + 1'b1;
                        frame_err <= (s_axis_tlast[grant] != cnt_last);
`endif
                        if (eof) begin
                            state <= IDLE;
                            ptr   <= (grant == IW'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_frame_arbiter.sv
// tb_stream_frame_arbiter
// Directed bench for stream_frame_arbiter with NUM_SRC=2, BEATS=4. Each source
// emits frames whose sample re values run 0..15 and whose imag part encodes
// {source, frame}; the merged output is checked beat by beat against the
// expected round-robin frame order. Define STREAM_FRAME_ARB_LEN_CHECK_EN to
// also exercise the frame length checker.

module tb_stream_frame_arbiter;

    localparam int NS    = 2;
    localparam int W     = 16;
    localparam int SPC   = 4;
    localparam int FL    = 16;
    localparam int BEATS = FL / SPC;
    localparam int DW    = SPC * 2 * W;

    logic             clk = 1'b0;
    logic             rst;
    logic [NS*DW-1:0] s_axis_tdata;
    logic [NS-1:0]    s_axis_tvalid;
    logic [NS-1:0]    s_axis_tlast;
    logic [NS-1:0]    s_axis_tready;
    logic [DW-1:0]    m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic [0:0]       m_axis_tuser;
    logic             m_axis_tready;
    logic             frame_err;

    int tests    = 0;
    int failures = 0;

    int       src_beat [NS];
    int       src_frame[NS];
    bit [NS-1:0] src_en;
    int       early_last_src;
    int       out_k;
    bit       m_ready;
    bit       err_exp;
    int       err_cnt;

    logic          obs_valid;
    logic          obs_last;
    logic [DW-1:0] obs_data;
    logic [0:0]    obs_user;
    logic          obs_err;
    logic [NS-1:0] obs_tready;

    bit [31:0] ready_pat = 32'h6A3C_95D2;

    always #5 clk = ~clk;

    stream_frame_arbiter #(
        .NUM_SRC      (NS),
        .WIDTH        (W),
        .SAMP_PER_CLK (SPC),
        .FFT_LEN      (FL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .frame_err     (frame_err)
    );

    // Beat b of frame fr from source src: re = b*SPC+j, imag = src*256+fr.
    function automatic logic [DW-1:0] make_beat(input int src, input int fr, input int b);
        logic [DW-1:0] d;
        logic [15:0]   re;
        logic [15:0]   im;
        d = '0;
        for (int j = 0; j < SPC; j++) begin
            re = 16'(b * SPC + j);
            im = 16'(src * 256 + fr);
            d[j*2*W +: 2*W] = {im, re};
        end
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_tvalid"}, DW'(obs_valid), '0);
        checkOutput({tag, "_tlast"},  DW'(obs_last),  '0);
        checkOutput({tag, "_tdata"},  obs_data,       '0);
        checkOutput({tag, "_tuser"},  DW'(obs_user),  '0);
        checkOutput({tag, "_sready"}, DW'(obs_tready), '0);
        checkOutput({tag, "_ferr"},   DW'(obs_err),   '0);
    endtask

    // One clock cycle: sample outputs, drive sources and sink, score any
    // consumed output beat, then advance the source models on handshakes.
    task automatic applyStimulus(input bit rst_val);
        logic [NS-1:0] hs;
        int            e_src;
        int            e_fr;
        int            e_b;
        @(negedge clk);
        obs_valid = m_axis_tvalid;
        obs_last  = m_axis_tlast;
        obs_data  = m_axis_tdata;
        obs_user  = m_axis_tuser;
        obs_err   = frame_err;
        rst = rst_val;
        for (int i = 0; i < NS; i++) begin
            s_axis_tvalid[i]          = src_en[i];
            s_axis_tdata[i*DW +: DW]  = make_beat(i, src_frame[i], src_beat[i]);
            s_axis_tlast[i]           = (src_beat[i] == BEATS - 1) ||
                                        (early_last_src == i && src_beat[i] == 1);
        end
        m_axis_tready = m_ready;
        #1;
        obs_tready = s_axis_tready;
        hs = s_axis_tvalid & s_axis_tready;
        checkOutput("frame_err", DW'(obs_err), DW'(err_exp));
        if (m_axis_tvalid && m_axis_tready) begin
            e_src = (out_k / BEATS) % NS;
            e_fr  = out_k / (BEATS * NS);
            e_b   = out_k % BEATS;
            checkOutput($sformatf("tuser_k%0d", out_k), DW'(m_axis_tuser), DW'(e_src));
            checkOutput($sformatf("tlast_k%0d", out_k), DW'(m_axis_tlast), DW'(e_b == BEATS - 1));
            checkOutput($sformatf("tdata_k%0d", out_k), m_axis_tdata, make_beat(e_src, e_fr, e_b));
            out_k++;
        end
        @(posedge clk);
        err_exp = 1'b0;
        if (rst_val) begin
            for (int i = 0; i < NS; i++) begin
                src_beat[i]  = 0;
                src_frame[i] = 0;
            end
            out_k = 0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (hs[i]) begin
`ifdef STREAM_FRAME_ARB_LEN_CHECK_EN
                    if (s_axis_tlast[i] != (src_beat[i] == BEATS - 1)) begin
                        err_exp = 1'b1;
                    end
`endif
                    if (src_beat[i] == BEATS - 1) begin
                        src_beat[i] = 0;
                        src_frame[i]++;
                        if (early_last_src == i) begin
                            early_last_src = -1;
                        end
                    end else begin
                        src_beat[i]++;
                    end
                end
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        s_axis_tdata   = '0;
        s_axis_tvalid  = '0;
        s_axis_tlast   = '0;
        m_axis_tready  = 1'b1;
        m_ready        = 1'b1;
        src_en         = '1;
        early_last_src = -1;
        out_k          = 0;
        err_exp        = 1'b0;
        for (int i = 0; i < NS; i++) begin
            src_beat[i]  = 0;
            src_frame[i] = 0;
        end

        // Reset held for 3 cycles with every source valid.
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkIdle("rst_hold1");
        applyStimulus(1'b1);
        checkIdle("rst_hold2");
        applyStimulus(1'b0);
        checkIdle("rst_release");

        // Both sources continuously valid: 4 beats, bubble, 4 beats, bubble ...
        for (int t = 1; t < 22; t++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("valid_pattern_t%0d", t), DW'(obs_valid),
                        DW'(t >= 2 && ((t - 2) % 5) != 4));
        end
        checkOutput("continuous_beats", DW'(out_k), DW'(16));

        // Downstream backpressure from a fixed toggling pattern.
        applyStimulus(1'b1);
        for (int c = 0; c < 200 && out_k < 16; c++) begin
            m_ready = ready_pat[c % 32];
            applyStimulus(1'b0);
        end
        m_ready = 1'b1;
        checkOutput("backpressure_beats", DW'(out_k), DW'(16));

        // Source 0 stalls after 2 beats; source 1 must keep waiting.
        applyStimulus(1'b1);
        for (int c = 0; c < 20 && src_beat[0] != 2; c++) begin
            applyStimulus(1'b0);
        end
        src_en[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b0);
            checkOutput("stall_ready1", DW'(obs_tready[1]), '0);
            checkOutput("stall_ready0_held", DW'(obs_tready[0]), DW'(1));
        end
        src_en[0] = 1'b1;
        for (int c = 0; c < 20 && src_frame[0] != 1; c++) begin
            applyStimulus(1'b0);
            checkOutput("resume_ready1", DW'(obs_tready[1]), '0);
        end
        checkOutput("stall_src0_done", DW'(src_frame[0]), DW'(1));
        checkOutput("stall_src1_untouched", DW'(src_beat[1]), '0);
        for (int c = 0; c < 30 && out_k < 8; c++) begin
            applyStimulus(1'b0);
        end
        checkOutput("stall_beats", DW'(out_k), DW'(8));

        // Reset in the middle of source 1's frame, after its third beat.
        applyStimulus(1'b1);
        for (int c = 0; c < 30 && !(src_frame[0] == 1 && src_beat[1] == 3); c++) begin
            applyStimulus(1'b0);
        end
        checkOutput("pre_reset_src1_beats", DW'(src_beat[1]), DW'(3));
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        checkIdle("mid_reset");
        for (int c = 0; c < 10 && out_k < 1; c++) begin
            applyStimulus(1'b0);
        end
        checkOutput("post_reset_first_beat", DW'(out_k), DW'(1));

`ifdef STREAM_FRAME_ARB_LEN_CHECK_EN
        // Source 0 raises tlast early on its second beat as well as on the fourth.
        applyStimulus(1'b1);
        early_last_src = 0;
        err_cnt        = 0;
        for (int c = 0; c < 30 && out_k < 4; c++) begin
            applyStimulus(1'b0);
            if (obs_err) begin
                err_cnt++;
            end
        end
        checkOutput("early_tlast_err_pulses", DW'(err_cnt), DW'(1));
        checkOutput("early_tlast_frame_beats", DW'(out_k), DW'(4));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/stream_frame_arbiter.md
# stream_frame_arbiter

Frame-aligned round-robin arbiter that merges `NUM_SRC` AXI4-Stream sources of packed complex sample vectors into a single stream for the FFT/PFB datapath. Grants are held for exactly one FFT frame of `FFT_LEN/SAMP_PER_CLK` beats, so frames are never interleaved. The output is one registered pipeline stage and carries the granted source index on `tuser`. It sits between test-pattern or ADC sources (impulse generators, capture replay) and the FFT input.

## Interface

- `NUM_SRC`, 2: number of input streams; range 2..8.
- `WIDTH`, 16: bits per real/imag component.
- `SAMP_PER_CLK`, 4: complex samples per beat.
- `FFT_LEN`, 16: samples per frame; must be a multiple of `SAMP_PER_CLK`.
- Derived: `BEATS = FFT_LEN/SAMP_PER_CLK`, `DW = SAMP_PER_CLK*2*WIDTH`, `IW = max(1,$clog2(NUM_SRC))`.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `s_axis_tdata`  in  `NUM_SRC*DW`  source `i` occupies bits `[i*DW +: DW]`. Within each beat, sample `j` is in `[j*2*WIDTH +: 2*WIDTH]`, with imag in the upper half and real in the lower half.
- `s_axis_tvalid`  in  `NUM_SRC`  per-source valid.
- `s_axis_tlast`  in  `NUM_SRC`  per-source end of frame.
- `s_axis_tready`  out  `NUM_SRC`  per-source ready.
- `m_axis_tdata`  out  `DW`  merged data, passed through unmodified.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tlast`  out  1  last beat of frame.
- `m_axis_tuser`  out  `IW`  index of the source that produced the beat.
- `m_axis_tready`  in  1  downstream ready.
- `frame_err`  out  1  one-cycle pulse on a framing mismatch; see Configuration.

## Operation

- **FSM states:** IDLE, BUSY.
- **IDLE:**
  - Scan `s_axis_tvalid` round-robin, starting at `ptr`.
  - The first valid source becomes `grant`; the FSM moves to BUSY on the next edge.
  - If no source is valid, stay in IDLE.
  - No beats are accepted in IDLE.
- **BUSY:**
  - `s_axis_tready[grant] = !m_axis_tvalid || m_axis_tready`. All other `s_axis_tready` bits are 0.
  - An accepted beat satisfies `s_axis_tvalid[grant] && s_axis_tready[grant]`.
  - On an accepted beat, the output register loads data, `tuser=grant`, `tvalid=1`, and `tlast` per Configuration. `beat_cnt` increments.
  - When the end-of-frame beat is accepted: FSM returns to IDLE, `beat_cnt` clears to 0, and `ptr = (grant+1) mod NUM_SRC`.
- **Output register:** `m_axis_tvalid` clears when `m_axis_tready=1` and no new beat is loaded in the same cycle.
- **`beat_cnt`:** width `$clog2(BEATS)` with a minimum of 1; it wraps only through the end-of-frame clear.
- **Source stalls mid-frame** (`tvalid` low while BUSY): the grant is held indefinitely and other sources wait.
- **Simultaneous requests** in IDLE: the first valid index at or after `ptr` wins. With all sources continuously valid, grants cycle 0,1,…,NUM_SRC-1,0.
- **Reset mid-frame:** the partial frame is abandoned with no flush.
  - FSM = IDLE, `ptr` = 0, `beat_cnt` = 0.
  - Reset values: `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`, `m_axis_tuser=0`, `s_axis_tready=0`, `frame_err=0`.

## Timing

- **Arbitration gap:** IDLE→BUSY costs one cycle. Back-to-back frames therefore have a one-cycle bubble on `m_axis_tvalid`.
- **Latency:** one cycle from an accepted input beat to `m_axis_tvalid`.
- **Sustained throughput:** one beat per cycle within a frame while `m_axis_tready=1`.
- **Backpressure:** `s_axis_tready[grant]` depends combinationally on `m_axis_tready`. No data is dropped or duplicated under any `tready` pattern.
- **`frame_err`:** asserts in the cycle after the offending beat is accepted, for exactly one cycle.
- **Source expectations:** sources must hold `tdata`/`tlast` stable while `tvalid && !tready`.

## Configuration

- **Macro:** `STREAM_FRAME_ARB_LEN_CHECK_EN`.
- **Defined:**
  - The frame ends on the count: the beat accepted with `beat_cnt==BEATS-1`. `m_axis_tlast` is generated from the count.
  - `frame_err` pulses when the accepted `s_axis_tlast[grant]` differs from `(beat_cnt==BEATS-1)`.
  - Source `tlast` is otherwise ignored.
- **Undefined:**
  - The frame ends on an accepted beat with `s_axis_tlast[grant]=1`, and `m_axis_tlast` passes that bit through.
  - `beat_cnt` is not implemented, and `frame_err` is tied to 0.

## Test plan

- **Reset values:** hold `rst` for 3 cycles with all sources valid → every output stays 0. The first grant after release goes to source 0.
- **Two sources, continuous:** `NUM_SRC=2`, `BEATS=4`, both always valid, `m_axis_tready=1`. Expected `tuser` sequence: 0,0,0,0,(bubble),1,1,1,1,(bubble),0…; `tlast` is set on every 4th beat; `re` values are 0..15 per source in order.
- **Random backpressure:** toggle `m_axis_tready` at 50% → the output beat sequence is identical to the no-stall run, with no loss or duplication.
- **Mid-frame source stall:** source 0 drops `tvalid` after 2 beats while source 1 is valid → source 1 receives no `tready` until source 0 completes its remaining 2 beats.
- **Early `tlast`, checker enabled:** source 0 asserts `tlast` on beat 2 with the macro defined → `frame_err` is a single-cycle pulse, the frame still ends at beat 4, and `m_axis_tlast` is set only on beat 4.
- **Reset mid-frame:** assert `rst` after beat 2 of source 1 → all outputs return to reset values, and the next grant goes to source 0 starting at beat 0.
